// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the push-button conditioning front end.
package button_conditioner_pkg;

  localparam int LED_W = 6;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin; shared by other pin front ends.
module sync_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic sync1_reg;
  logic s_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      s_reg     <= 1'b0;
    end else begin
      sync1_reg <= d;
      s_reg     <= sync1_reg;
    end
  end

  assign q = s_reg;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronise, debounce, and derive level, press/release/long-press
// strobes and a wrapping press counter for the LEDs.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int LONG_PRESS_CYCLES = 25000000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             button,
  output logic             button_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_press,
  output logic [LED_W-1:0] press_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

  logic s;

  state_t            state_reg;
  logic [DB_W-1:0]   db_cnt_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              long_fired_reg;
  logic              level_reg;
  logic              press_pulse_reg;
  logic              release_pulse_reg;
  logic              long_press_reg;
  logic [LED_W-1:0]  press_count_reg;

  sync_2ff u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (button),
    .q       (s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      db_cnt_reg        <= '0;
      hold_cnt_reg      <= '0;
      long_fired_reg    <= 1'b0;
      level_reg         <= 1'b0;
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;
      long_press_reg    <= 1'b0;
      press_count_reg   <= '0;
    end else begin
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;
      long_press_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (s) begin
            state_reg  <= PRESS_WAIT;
            db_cnt_reg <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_reg <= IDLE;
          end else if (db_cnt_reg == DB_LAST) begin
            state_reg       <= PRESSED;
            press_pulse_reg <= 1'b1;
            level_reg       <= 1'b1;
            press_count_reg <= press_count_reg + 1'b1;
            hold_cnt_reg    <= '0;
            long_fired_reg  <= 1'b0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
        PRESSED: begin
          if (hold_cnt_reg != HOLD_MAX) hold_cnt_reg <= hold_cnt_reg + 1'b1;
          // The fired flag survives release bounces, so one press yields one long strobe.
          if (hold_cnt_reg == HOLD_LAST && !long_fired_reg) begin
            long_press_reg <= 1'b1;
            long_fired_reg <= 1'b1;
          end
          if (!s) begin
            state_reg  <= RELEASE_WAIT;
            db_cnt_reg <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (hold_cnt_reg != HOLD_MAX) hold_cnt_reg <= hold_cnt_reg + 1'b1;
          if (s) begin
            state_reg <= PRESSED;
          end else if (db_cnt_reg == DB_LAST) begin
            state_reg         <= IDLE;
            release_pulse_reg <= 1'b1;
            level_reg         <= 1'b0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign button_level  = level_reg;
  assign press_pulse   = press_pulse_reg;
  assign release_pulse = release_pulse_reg;
  assign long_press    = long_press_reg;
  assign press_count   = press_count_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner, compared every cycle to a run-length model.
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 10;

  logic       clock;
  logic       reset_n;
  logic       button;
  logic       button_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press;
  logic [5:0] press_count;

  button_conditioner #(
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONG)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .button        (button),
    .button_level  (button_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .press_count   (press_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_press, n_rel, n_long;
  int last_press_cyc, last_long_cyc;

  // Model: the level flips once the synchronised pin has disagreed with it on DEB+1
  // consecutive edges; age counts edges since the accepted press.
  logic m_sync1, m_s, m_level, m_fired;
  logic m_press, m_rel, m_long;
  int   m_run, m_age, m_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_sync1 = 0; m_s = 0; m_level = 0; m_fired = 0;
    m_press = 0; m_rel = 0; m_long = 0;
    m_run = 0; m_age = 0; m_count = 0;
  endtask

  task automatic model_edge(input logic b);
    logic samp;
    samp    = m_s;
    m_s     = m_sync1;
    m_sync1 = b;
    m_press = 0; m_rel = 0; m_long = 0;
    if (m_level && m_run == 0 && m_age == LONG - 1 && !m_fired) begin
      m_long  = 1;
      m_fired = 1;
    end
    if (m_level) m_age++;
    if (samp != m_level) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_level = !m_level;
        m_run   = 0;
        if (m_level) begin
          m_press = 1;
          m_count = (m_count + 1) % 64;
          m_age   = 0;
          m_fired = 0;
        end else begin
          m_rel = 1;
        end
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic step(input logic b);
    button = b;
    @(posedge clock);
    #1;
    cyc++;
    model_edge(b);
    check("level", button_level, m_level);
    check("press", press_pulse, m_press);
    check("release", release_pulse, m_rel);
    check("long", long_press, m_long);
    check("count", press_count, m_count);
    if (press_pulse) begin n_press++; last_press_cyc = cyc; end
    if (release_pulse) n_rel++;
    if (long_press) begin n_long++; last_long_cyc = cyc; end
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_long = 0;
    last_press_cyc = -1; last_long_cyc = -1;
  endtask

  // Assert reset between edges, confirm the asynchronous clear, then release it.
  task automatic do_reset(input logic hold_button);
    button  = hold_button;
    reset_n = 1'b0;
    #2;
    check("rst_level", button_level, 1'b0);
    check("rst_press", press_pulse, 1'b0);
    check("rst_release", release_pulse, 1'b0);
    check("rst_long", long_press, 1'b0);
    check("rst_count", press_count, 6'd0);
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic press_after_reset(input string tag);
    int cap;
    int lat;
    cap = cyc + 1;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      if (press_pulse && lat < 0) lat = cyc - cap;
    end
    check(tag, lat, 6);
  endtask

  initial begin
    int cap;
    int lvl;
    int len;
    reset_n = 1'b0;
    button  = 1'b0;
    model_clear();
    clear_counts();
    #12;
    do_reset(1'b0);

    for (int i = 0; i < 20; i++) step(1'b0);
    $display("idle after reset: count=%0d level=%0d", press_count, button_level);

    clear_counts();
    cap = cyc + 1;
    for (int i = 0; i < 30; i++) step(1'b1);
    check("p1_npress", n_press, 1);
    check("p1_latency", last_press_cyc - cap, 6);
    check("p1_nlong", n_long, 1);
    check("p1_long_delay", last_long_cyc - last_press_cyc, 10);
    check("p1_level", button_level, 1'b1);
    check("p1_count", press_count, 6'd1);
    for (int i = 0; i < 20; i++) step(1'b0);
    check("p1_nrel", n_rel, 1);
    $display("stable press: presses=%0d longs=%0d releases=%0d", n_press, n_long, n_rel);

    clear_counts();
    for (int i = 0; i < 2; i++) step(1'b1);
    for (int i = 0; i < 2; i++) step(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 2; i++) step(1'b0);
    for (int i = 0; i < 1; i++) step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0);
    check("bounce_npress", n_press + n_rel + n_long, 0);
    check("bounce_count", press_count, 6'd1);
    $display("short bounces: pulses=%0d count=%0d", n_press + n_rel + n_long, press_count);

    clear_counts();
    for (int i = 0; i < 20; i++) step(1'b1);
    for (int i = 0; i < 2; i++) step(1'b0);
    for (int i = 0; i < 15; i++) step(1'b1);
    check("glitch_nrel_held", n_rel, 0);
    for (int i = 0; i < 20; i++) step(1'b0);
    check("glitch_npress", n_press, 1);
    check("glitch_nlong", n_long, 1);
    check("glitch_nrel", n_rel, 1);
    check("glitch_level", button_level, 1'b0);
    $display("held press with glitch: presses=%0d longs=%0d releases=%0d", n_press, n_long, n_rel);

    step(1'b0);
    do_reset(1'b0);
    for (int p = 1; p <= 64; p++) begin
      for (int i = 0; i < 8; i++) step(1'b1);
      for (int i = 0; i < 8; i++) step(1'b0);
      if (p == 63) check("wrap_63", press_count, 6'd63);
    end
    check("wrap_0", press_count, 6'd0);
    $display("64 presses: count=%0d", press_count);

    for (int i = 0; i < 3; i++) step(1'b1);
    do_reset(1'b1);
    press_after_reset("rst_press_wait_latency");
    do_reset(1'b1);
    press_after_reset("rst_pressed_latency");
    for (int i = 0; i < 10; i++) step(1'b0);
    $display("reset mid-press: count=%0d level=%0d", press_count, button_level);

    lvl = 0;
    for (int r = 0; r < 300; r++) begin
      lvl = 1 - lvl;
      if ($urandom_range(0, 5) == 0) len = int'($urandom_range(10, 30));
      else len = int'($urandom_range(1, 9));
      for (int i = 0; i < len; i++) step(lvl[0]);
    end
    $display("random phase done: cycle=%0d count=%0d", cyc, press_count);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
